// File: rtl/bp_fe_queue_buffer_pkg.sv
// Shared constants for the FE-side instruction queue buffer.
package bp_fe_queue_buffer_pkg;

    localparam int fe_queue_width_gp = 32;
    localparam int fe_queue_els_gp   = 8;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/bp_fe_queue_buffer_if.sv
// FE packet input plus BE issue/commit/replay controls of the queue buffer.
interface bp_fe_queue_buffer_if #(parameter int width_p = 32);

    logic [width_p-1:0] fe_queue_i;
    logic               fe_queue_v_i;
    logic               fe_queue_ready_o;
    logic [width_p-1:0] fe_queue_o;
    logic               fe_queue_v_o;
    logic               fe_queue_yumi_i;
    logic               fe_queue_deq_i;
    logic               fe_queue_roll_i;
    logic               fe_queue_clr_i;
    logic               empty_o;

    modport master (
        output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, fe_queue_deq_i,
               fe_queue_roll_i, fe_queue_clr_i,
        input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o, empty_o
    );

    modport slave (
        input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, fe_queue_deq_i,
               fe_queue_roll_i, fe_queue_clr_i,
        output fe_queue_ready_o, fe_queue_o, fe_queue_v_o, empty_o
    );

endinterface

// File: rtl/bp_fe_queue_buffer_mem.sv
// 1R1W storage array: synchronous write, asynchronous read, contents not reset.
module bp_fe_queue_buffer_mem #(
    parameter int width_p       = 32,
    parameter int els_p         = 8,
    parameter int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) mem_q[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_buffer.sv
// FE instruction queue with speculative issue pointer and commit pointer so the
// BE can replay issued-but-uncommitted packets, or clear everything on redirect.
module bp_fe_queue_buffer
    import bp_fe_queue_buffer_pkg::*;
#(
    parameter int fe_queue_width_p = fe_queue_width_gp,
    parameter int els_p            = fe_queue_els_gp
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_fe_queue_buffer_if.slave   q_if
);

    localparam int lg_els_lp    = $clog2(els_p);
    localparam int ptr_width_lp = lg_els_lp + 1;
    localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);
    localparam logic [ptr_width_lp-1:0] ptr_els_lp = ptr_width_lp'(els_p);

    if (!is_pow2(els_p) || els_p < 2) begin : g_bad_els
        $error("bp_fe_queue_buffer: els_p must be a power of 2 and at least 2");
    end

    logic [ptr_width_lp-1:0] wptr_q, wptr_d;
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [ptr_width_lp-1:0] cptr_q, cptr_d;
    logic [ptr_width_lp-1:0] cptr_n;
    logic full, enq, deq, yumi;

    // Flags come only from registered pointers; no input feeds ready/v.
    assign full = (wptr_q[ptr_width_lp-1] != cptr_q[ptr_width_lp-1])
               && (wptr_q[lg_els_lp-1:0] == cptr_q[lg_els_lp-1:0]);

    assign q_if.fe_queue_ready_o = ~full;
    assign q_if.fe_queue_v_o     = (rptr_q != wptr_q);
    assign q_if.empty_o          = (cptr_q == wptr_q);

    assign enq  = q_if.fe_queue_v_i & ~full;
    assign deq  = q_if.fe_queue_deq_i & ~q_if.fe_queue_clr_i;
    assign yumi = q_if.fe_queue_yumi_i & ~q_if.fe_queue_clr_i & ~q_if.fe_queue_roll_i;

    always_comb begin
        wptr_d = enq ? wptr_q + ptr_one_lp : wptr_q;
        cptr_n = deq ? cptr_q + ptr_one_lp : cptr_q;
        cptr_d = cptr_n;
        rptr_d = yumi ? rptr_q + ptr_one_lp : rptr_q;
        if (q_if.fe_queue_clr_i) begin
            // A same-cycle enqueue still advances wptr but lands outside the contents.
            rptr_d = wptr_d;
            cptr_d = wptr_d;
        end else if (q_if.fe_queue_roll_i) begin
            rptr_d = cptr_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    bp_fe_queue_buffer_mem #(
        .width_p (fe_queue_width_p),
        .els_p   (els_p)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (enq),
        .w_addr_i (wptr_q[lg_els_lp-1:0]),
        .w_data_i (q_if.fe_queue_i),
        .r_addr_i (rptr_q[lg_els_lp-1:0]),
        .r_data_o (q_if.fe_queue_o)
    );

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi |-> q_if.fe_queue_v_o)
        else $error("bp_fe_queue_buffer: yumi with no unissued packet");

    a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        deq |-> (cptr_q != rptr_q))
        else $error("bp_fe_queue_buffer: deq of an unissued packet");

    a_occupancy: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        ((wptr_q - cptr_q) <= ptr_els_lp) && ((wptr_q - rptr_q) <= (wptr_q - cptr_q)))
        else $error("bp_fe_queue_buffer: pointer ordering violated");

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// Directed bench for bp_fe_queue_buffer with els_p=4 and 32-bit packets.
module tb_bp_fe_queue_buffer;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bp_fe_queue_buffer_if #(.width_p(W)) q_if ();

    bp_fe_queue_buffer #(.fe_queue_width_p(W), .els_p(4)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .q_if      (q_if.slave)
    );

    localparam logic [W-1:0] PA = 32'hA000_000A, PB = 32'hB000_000B, PC = 32'hC000_000C;
    localparam logic [W-1:0] PD = 32'hD000_000D, PX = 32'h5A5A_0001, PE = 32'hE000_000E;
    localparam logic [W-1:0] PG = 32'h6666_0006, PH = 32'h1111_0001, PI = 32'h2222_0002;
    localparam logic [W-1:0] PJ = 32'h3333_0003, PF = 32'hF000_000F;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        q_if.fe_queue_v_i    = 1'b0;
        q_if.fe_queue_yumi_i = 1'b0;
        q_if.fe_queue_deq_i  = 1'b0;
        q_if.fe_queue_roll_i = 1'b0;
        q_if.fe_queue_clr_i  = 1'b0;
    endtask

    task automatic enq(input logic [W-1:0] p);
        q_if.fe_queue_i = p; q_if.fe_queue_v_i = 1'b1; tick(); idle();
    endtask

    task automatic yumi();
        q_if.fe_queue_yumi_i = 1'b1; tick(); idle();
    endtask

    initial begin
        q_if.fe_queue_i = '0;
        idle();

        // reset
        tick(); tick();
        reset_n = 1'b1;
        chk("rst_ready", W'(q_if.fe_queue_ready_o), 1);
        chk("rst_v",     W'(q_if.fe_queue_v_o), 0);
        chk("rst_empty", W'(q_if.empty_o), 1);

        // fill A..D, v_o only after the first edge
        q_if.fe_queue_i = PA; q_if.fe_queue_v_i = 1'b1;
        #1 chk("no_bypass_v", W'(q_if.fe_queue_v_o), 0);
        tick(); idle();
        chk("a_v",  W'(q_if.fe_queue_v_o), 1);
        chk("a_out", q_if.fe_queue_o, PA);
        enq(PB); enq(PC);
        chk("c_ready", W'(q_if.fe_queue_ready_o), 1);
        enq(PD);
        chk("d_ready", W'(q_if.fe_queue_ready_o), 0);
        chk("d_out",   q_if.fe_queue_o, PA);
        chk("d_empty", W'(q_if.empty_o), 0);

        // yumi A,B; deq A; roll back to B
        yumi();
        chk("yumi_a", q_if.fe_queue_o, PB);
        yumi();
        chk("yumi_b", q_if.fe_queue_o, PC);
        q_if.fe_queue_deq_i = 1'b1; tick(); idle();
        chk("deq_ready", W'(q_if.fe_queue_ready_o), 1);
        q_if.fe_queue_roll_i = 1'b1; tick(); idle();
        chk("roll_out", q_if.fe_queue_o, PB);
        chk("roll_v",   W'(q_if.fe_queue_v_o), 1);
        yumi();
        chk("reyumi_b", q_if.fe_queue_o, PC);

        // fill to 4 (X wraps to slot 0), issue all, then deq+roll
        enq(PX);
        chk("x_full", W'(q_if.fe_queue_ready_o), 0);
        yumi(); yumi(); yumi();
        chk("all_issued_v", W'(q_if.fe_queue_v_o), 0);
        q_if.fe_queue_deq_i = 1'b1; q_if.fe_queue_roll_i = 1'b1; tick(); idle();
        chk("deqroll_ready", W'(q_if.fe_queue_ready_o), 1);
        chk("deqroll_out",   q_if.fe_queue_o, PC);
        enq(PE);
        chk("e_full", W'(q_if.fe_queue_ready_o), 0);
        yumi();
        chk("replay_d", q_if.fe_queue_o, PD);
        yumi();
        chk("replay_x", q_if.fe_queue_o, PX);
        yumi();
        chk("e_after", q_if.fe_queue_o, PE);

        // make room, then clr with simultaneous enqueue and yumi
        q_if.fe_queue_deq_i = 1'b1; tick(); idle();
        q_if.fe_queue_clr_i = 1'b1; q_if.fe_queue_yumi_i = 1'b1;
        q_if.fe_queue_i = PG; q_if.fe_queue_v_i = 1'b1;
        tick(); idle();
        chk("clr_v",     W'(q_if.fe_queue_v_o), 0);
        chk("clr_empty", W'(q_if.empty_o), 1);
        chk("clr_ready", W'(q_if.fe_queue_ready_o), 1);
        tick();
        chk("clr_g_hidden", W'(q_if.fe_queue_v_o), 0);

        // roll+yumi with two issued-uncommitted entries
        enq(PH); enq(PI); enq(PJ);
        yumi(); yumi();
        chk("pre_roll_out", q_if.fe_queue_o, PJ);
        q_if.fe_queue_roll_i = 1'b1; q_if.fe_queue_yumi_i = 1'b1; tick(); idle();
        chk("rollyumi_out", q_if.fe_queue_o, PH);
        chk("rollyumi_v",   W'(q_if.fe_queue_v_o), 1);
        chk("rollyumi_empty", W'(q_if.empty_o), 0);

        // reset while three entries are held
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        chk("mid_rst_empty", W'(q_if.empty_o), 1);
        chk("mid_rst_v",     W'(q_if.fe_queue_v_o), 0);
        chk("mid_rst_ready", W'(q_if.fe_queue_ready_o), 1);
        enq(PF);
        chk("f_out", q_if.fe_queue_o, PF);
        chk("f_v",   W'(q_if.fe_queue_v_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
